// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, beq and j,
// stalls memory states on mem_ready, and raises a sticky err on an illegal
// opcode or a memory access that exceeds MEM_TIMEOUT stalled cycles.
module multicycle_main_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALU_OP,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Last stalled-cycle count before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;
  logic       err_set;
  logic       mem_wait;
  logic       timeout;

  // The branch decision is gated by zero in the datapath; the controller only receives it.
  logic unused_zero;
  assign unused_zero = zero;

  // Next-state, stall counter and error-event decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    err_set  = 1'b0;
    mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
               && !mem_ready;
    timeout  = mem_wait && (cnt_q == TO_LAST);
    if (mem_wait && !timeout) cnt_d = cnt_q + 8'd1;

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REXE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            err_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXE:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase

    // A timed-out access abandons the instruction and refetches.
    if (timeout) begin
      state_d = S_FETCH;
      err_set = 1'b1;
    end
  end

  // State, stall counter and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_set;
    end
  end

  // Datapath controls decoded from the current state (and mem_ready in FETCH).
  always_comb begin
    ALU_OP      = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXE: begin
        ALUSrcA = 1'b1;
        ALU_OP  = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_OP      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Scoreboard bench for multicycle_main_ctrl: each directed cycle pushes its
// expected state/controls/err; a negedge monitor pops and compares.
module tb_multicycle_main_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALU_OP;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       err;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_REXE   = 4'd7;
  localparam logic [3:0] ST_RWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JUMP   = 4'd10;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    int         idx;
    logic [3:0] st;
    logic [15:0] ctrl;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec      = 0;

  multicycle_main_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALU_OP(ALU_OP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .state(state), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control word: {ALU_OP, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
  //                MemtoReg, RegDst, RegWrite, PCWrite, PCWriteCond, PCSource}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic [1:0] aop, srcb, pcs;
    logic srca, iord, mrd, mwr, irw, m2r, rdst, rw, pcw, pcwc;
    aop = 2'b00; srcb = 2'b00; pcs = 2'b00;
    srca = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0; rw = 0; pcw = 0; pcwc = 0;
    case (st)
      ST_FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE: srcb = 2'b11;
      ST_MEMADR: begin srca = 1; srcb = 2'b10; end
      ST_MEMRD:  begin mrd = 1; iord = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; end
      ST_MEMWR:  begin mwr = 1; iord = 1; end
      ST_REXE:   begin srca = 1; aop = 2'b10; end
      ST_RWB:    begin rw = 1; rdst = 1; end
      ST_BRANCH: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      ST_JUMP:   begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {aop, srca, srcb, iord, mrd, mwr, irw, m2r, rdst, rw, pcw, pcwc, pcs};
  endfunction

  // One cycle of stimulus: drive inputs, record what the DUT must show this cycle.
  task automatic step(input logic r, input logic [5:0] opc, input logic z,
                      input logic mr, input logic [3:0] st, input logic e);
    exp_t x;
    rst = r; opcode = opc; zero = z; mem_ready = mr;
    x.idx = vec; x.st = st; x.ctrl = exp_ctrl(st, mr); x.e = e;
    sb.push_back(x);
    vec++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec %0d: got %0h want %0h", name, idx, got, want);
  endtask

  // Monitor: compare every cycle's outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    logic [15:0] act;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      act = {ALU_OP, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, PCWrite, PCWriteCond, PCSource};
      chk("state", x.idx, {12'd0, state}, {12'd0, x.st});
      chk("ctrl",  x.idx, act, x.ctrl);
      chk("err",   x.idx, {15'd0, err}, {15'd0, x.e});
    end
  end

  initial begin
    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset, release, R-type
    step(1, OP_R, 0, 1, ST_IDLE,   0);
    step(0, OP_R, 0, 1, ST_IDLE,   0);
    step(0, OP_R, 0, 1, ST_FETCH,  0);
    step(0, OP_R, 0, 1, ST_DECODE, 0);
    step(0, OP_R, 0, 1, ST_REXE,   0);
    step(0, OP_R, 0, 1, ST_RWB,    0);
    // lw
    step(0, OP_LW, 0, 1, ST_FETCH,  0);
    step(0, OP_LW, 0, 1, ST_DECODE, 0);
    step(0, OP_LW, 0, 1, ST_MEMADR, 0);
    step(0, OP_LW, 0, 1, ST_MEMRD,  0);
    step(0, OP_LW, 0, 1, ST_MEMWB,  0);
    // sw with three stalled cycles
    step(0, OP_SW, 0, 1, ST_FETCH,  0);
    step(0, OP_SW, 0, 1, ST_DECODE, 0);
    step(0, OP_SW, 0, 1, ST_MEMADR, 0);
    step(0, OP_SW, 0, 0, ST_MEMWR,  0);
    step(0, OP_SW, 0, 0, ST_MEMWR,  0);
    step(0, OP_SW, 0, 0, ST_MEMWR,  0);
    step(0, OP_SW, 0, 1, ST_MEMWR,  0);
    // beq taken then not taken
    step(0, OP_BEQ, 1, 1, ST_FETCH,  0);
    step(0, OP_BEQ, 1, 1, ST_DECODE, 0);
    step(0, OP_BEQ, 1, 1, ST_BRANCH, 0);
    step(0, OP_BEQ, 0, 1, ST_FETCH,  0);
    step(0, OP_BEQ, 0, 1, ST_DECODE, 0);
    step(0, OP_BEQ, 0, 1, ST_BRANCH, 0);
    // j
    step(0, OP_J, 0, 1, ST_FETCH,  0);
    step(0, OP_J, 0, 1, ST_DECODE, 0);
    step(0, OP_J, 0, 1, ST_JUMP,   0);
    // Fetch timeout: eight stalled cycles, then err and refetch
    for (int i = 0; i < 8; i++) step(0, OP_R, 0, 0, ST_FETCH, 0);
    step(0, OP_R, 0, 1, ST_FETCH,  1);
    step(0, OP_R, 0, 1, ST_DECODE, 1);
    step(0, OP_R, 0, 1, ST_REXE,   1);
    step(0, OP_R, 0, 1, ST_RWB,    1);
    // Reset clears err; illegal opcode sets it and it sticks
    step(1, OP_BAD, 0, 1, ST_IDLE,   0);
    step(0, OP_BAD, 0, 1, ST_IDLE,   0);
    step(0, OP_BAD, 0, 1, ST_FETCH,  0);
    step(0, OP_BAD, 0, 1, ST_DECODE, 0);
    step(0, OP_LW,  0, 1, ST_FETCH,  1);
    step(0, OP_LW,  0, 1, ST_DECODE, 1);
    step(0, OP_LW,  0, 1, ST_MEMADR, 1);
    step(0, OP_LW,  0, 0, ST_MEMRD,  1);
    // Async reset during MEMRD, then resume
    step(1, OP_LW, 0, 0, ST_IDLE,   0);
    step(0, OP_R,  0, 1, ST_IDLE,   0);
    step(0, OP_R,  0, 1, ST_FETCH,  0);
    step(0, OP_R,  0, 1, ST_DECODE, 0);
    step(0, OP_R,  0, 1, ST_REXE,   0);
    step(0, OP_R,  0, 1, ST_RWB,    0);
    @(negedge clk);
    #1;
    chk("drain", vec, 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Decodes the 6-bit opcode and sequences the datapath through fetch, decode, execute, memory and writeback steps.
- Produces the datapath enables and drives ALU_OP to the ALU_ctrl decoder. This block is the initiator side of the ALU_OP/funct interface.
- Supports lw, sw, R-type, beq and j. Memory accesses stall on a ready handshake.

Parameters:
- MEM_TIMEOUT, 8: maximum cycles to wait for mem_ready in any memory state before flagging an error (1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  instruction[31:26], taken from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed the current access this cycle
- ALU_OP  output  2  00 = add, 01 = subtract, 10 = use funct (to ALU_ctrl)
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load the instruction register
- MemtoReg  output  1  register writeback source: 1 = MDR
- RegDst  output  1  destination register: 1 = rd
- RegWrite  output  1  register file write enable
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by zero
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding (debug)
- err  output  1  sticky flag: illegal opcode or memory timeout

Behaviour:
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, REXE = 7, RWB = 8, BRANCH = 9, JUMP = 10. Encodings 11..15 go to IDLE.
- Reset (async, rst = 1): state = IDLE, wait counter = 0, err = 0. In IDLE every output is 0 (ALU_OP = 00, PCSource = 00, ALUSrcB = 00).
- Outputs are combinational from state, plus mem_ready where noted. Every signal not listed for a state is 0.
- IDLE -> FETCH, unconditionally, on the first edge after rst is released.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU_OP = 00, PCSource = 00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALU_OP = 00. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> REXE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> FETCH, and set err.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALU_OP = 00. Next: lw -> MEMRD, sw -> MEMWR. The opcode is re-sampled here; it is held stable by the instruction register.
- MEMRD: MemRead = 1, IorD = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Next: FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Wait for mem_ready, then go to FETCH.
- REXE: ALUSrcA = 1, ALUSrcB = 00, ALU_OP = 10. Next: RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Next: FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALU_OP = 01, PCWriteCond = 1, PCSource = 01. Next: FETCH. The PC loads only when zero = 1; the datapath does the gating.
- JUMP: PCWrite = 1, PCSource = 10. Next: FETCH.
- Instruction cycle counts with mem_ready tied to 1:
  - lw = 5
  - sw, R-type = 4
  - beq, j = 3
- Memory wait (FETCH, MEMRD, MEMWR):
  - The counter increments each cycle mem_ready = 0 and clears on leaving the state.
  - When the counter reaches MEM_TIMEOUT: set err and go to FETCH; MemRead and MemWrite drop the following cycle.
- err is sticky; only rst clears it. The FSM keeps running after err is set.
- rst asserted mid-instruction forces IDLE asynchronously. All enables deassert immediately, with no partial writeback.
- mem_ready = 1 in a non-memory state has no effect.

Test Plan:
- Reset, then mem_ready = 1 with opcode 000000 -> states 0,1,2,7,8,1. ALU_OP = 10 in REXE only. RegWrite = RegDst = 1 in RWB only.
- lw, opcode 100011, mem_ready = 1 -> states 1,2,3,4,5,1. IorD = 1 in MEMRD. MemtoReg = RegWrite = 1 in MEMWB.
- sw with mem_ready held 0 for 3 cycles in MEMWR -> stays in state 6 for 4 cycles, MemWrite = 1 throughout, then FETCH. err = 0.
- beq (000100) with zero = 1, then zero = 0 -> BRANCH shows ALU_OP = 01, PCWriteCond = 1, PCSource = 01 both times. j (000010) -> PCWrite = 1, PCSource = 10.
- Opcode 111111 in DECODE -> next state FETCH, err = 1 and stays 1 through later valid instructions. mem_ready stuck 0 in FETCH -> after 8 cycles, err set and FETCH re-entered.
- Assert rst during MEMRD -> state = 0 and MemRead = 0 in the same cycle, err = 0. After release, execution resumes at FETCH.
